// File: rtl/tensor_ram_reader.sv
// Streams len elements from a tensor RAM starting at base_addr, wrapping at DEPTH; first element two cycles after start.
// A 2-entry output FIFO plus one in-flight read absorbs out_ready stalls while keeping one element per cycle.
module tensor_ram_reader #(
  parameter int  D_WIDTH = 8,
  parameter int  DEPTH   = 96*96,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [AW-1:0]      base_addr,
  input  logic [AW:0]        len,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      ram_addr_r,
  input  logic [D_WIDTH-1:0] ram_dout,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = '0;

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t               state, state_nxt;
  logic [AW-1:0]        next_addr, last_addr;
  logic [AW:0]          reads_left, elems_left;
  logic                 inflight;
  logic [D_WIDTH-1:0]   fifo_mem [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           fifo_cnt;
  logic [2:0]           occupancy;
  logic                 hs, issue, last_hs, start_ok;

  assign hs        = out_valid && out_ready;
  assign last_hs   = hs && (elems_left == CNT_ONE);
  assign start_ok  = (state == IDLE) && start;
  // Slots already committed after this cycle's pop; a new read may take the last free one.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, hs};
  assign issue     = (state == STREAM) && (reads_left != CNT_ZERO) && (occupancy <= 3'd1);

  assign ram_addr_r = issue ? next_addr : last_addr;
  assign busy       = (state != IDLE);
  assign out_valid  = (fifo_cnt != 2'd0);
  assign out_data   = fifo_mem[rd_ptr];
  assign out_last   = out_valid && (elems_left == CNT_ONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == CNT_ZERO) ? FINISH : STREAM;
      STREAM:  if (last_hs) state_nxt = IDLE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      done        <= 1'b0;
      next_addr   <= '0;
      last_addr   <= '0;
      reads_left  <= '0;
      elems_left  <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      state <= state_nxt;
      done  <= last_hs || (start_ok && (len == CNT_ZERO));

      if (start_ok) begin
        next_addr  <= base_addr;
        reads_left <= len;
        elems_left <= len;
      end else begin
        if (issue) begin
          last_addr  <= next_addr;
          next_addr  <= (next_addr == ADDR_MAX) ? '0 : next_addr + ADDR_ONE;
          reads_left <= reads_left - CNT_ONE;
        end
        if (hs) elems_left <= elems_left - CNT_ONE;
      end

      // RAM data arrives the cycle after its address; capture it then.
      inflight <= issue;
      if (inflight) begin
        fifo_mem[wr_ptr] <= ram_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (hs) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, hs};
    end
  end

endmodule

// File: tb/tb_tensor_ram_reader.sv
// Randomized bench for tensor_ram_reader: a RAM model feeds the DUT, a queue of expected elements checks the stream.
`timescale 1ns/1ps
module tb_tensor_ram_reader;
  localparam int D_WIDTH = 8;
  localparam int DEPTH   = 96*96;
  localparam int AW      = $clog2(DEPTH);
  localparam int BUDGET  = 300;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [AW-1:0]      base_addr;
  logic [AW:0]        len;
  logic               busy, done;
  logic [AW-1:0]      ram_addr_r;
  logic [D_WIDTH-1:0] ram_dout;
  logic [D_WIDTH-1:0] out_data;
  logic               out_valid, out_ready, out_last;

  logic [D_WIDTH-1:0] mem [DEPTH];
  int vec_cnt = 0;
  int err_cnt = 0;
  int addr_log[$];
  bit val_log[$], last_log[$], busy_log[$], done_log[$];
  int done_n, done_k, got_n;
  int max_cnt = 0;

  tensor_ram_reader #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_addr_r(ram_addr_r), .ram_dout(ram_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data for an address appears the cycle after it is presented.
  always @(posedge clk) ram_dout <= mem[ram_addr_r];

  always @(negedge clk)
    if (reset_n && int'(dut.fifo_cnt) > max_cnt) max_cnt = int'(dut.fifo_cnt);

  task automatic chk(input string tag, input longint got, input longint exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One burst; log index i holds the cycle i+1 cycles after the start edge.
  task automatic run_burst(input int b, input int n, input bit rnd, input int spur_k, input int stop_after);
    logic [D_WIDTH-1:0] exp_q[$];
    logic [D_WIDTH-1:0] held_d;
    bit held_l, stalled, fin;
    exp_q = {};
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
    addr_log = {}; val_log = {}; last_log = {}; busy_log = {}; done_log = {};
    done_n = 0; done_k = -1; got_n = 0; stalled = 0; fin = 0; held_d = '0; held_l = 0;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(b); len = (AW+1)'(n); out_ready = 1'b1;
    for (int k = 1; k <= BUDGET && !fin; k++) begin
      @(negedge clk);
      start = (k == spur_k);
      if (k == spur_k) begin
        base_addr = AW'((b + 100) % DEPTH);
        len       = (AW+1)'(3);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      addr_log.push_back(int'(ram_addr_r));
      val_log.push_back(out_valid); last_log.push_back(out_last);
      busy_log.push_back(busy); done_log.push_back(done);
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (out_valid) begin
        chk("last_flag", out_last, got_n == n - 1);
        if (stalled) begin
          chk("hold_data", out_data, held_d);
          chk("hold_last", out_last, held_l);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) chk("elem_count", got_n + 1, n);
          else chk("data", out_data, exp_q.pop_front());
          got_n++;
          stalled = 0;
        end else begin
          stalled = 1; held_d = out_data; held_l = out_last;
        end
      end else if (stalled) begin
        chk("hold_valid", out_valid, 1);
        stalled = 0;
      end
      if (stop_after > 0 && got_n == stop_after) fin = 1;
      if (done_k > 0 && k > done_k) fin = 1;
    end
    start = 1'b0;
    if (stop_after == 0) begin
      chk("elems_received", got_n, n);
      chk("done_pulses", done_n, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    for (int i = 0; i < DEPTH; i++) mem[i] = D_WIDTH'($urandom);
    reset_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_addr", ram_addr_r, 0);
    chk("rst_data", out_data, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Full-rate burst timing.
    run_burst(10, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) chk("seq_addr", addr_log[i], 10 + i);
    chk("seq_valid_c1", val_log[0], 0);
    chk("seq_valid_c2", val_log[1], 0);
    for (int i = 2; i < 6; i++) chk("seq_valid", val_log[i], 1);
    chk("seq_valid_after", val_log[6], 0);
    chk("seq_last_3", last_log[4], 0);
    chk("seq_last_4", last_log[5], 1);
    chk("seq_done_cycle", done_k, 7);
    chk("seq_done_drop", done_log[7], 0);

    // Address wrap at a non-power-of-two depth.
    run_burst(DEPTH - 2, 4, 0, 0, 0);
    chk("wrap_a0", addr_log[0], DEPTH - 2);
    chk("wrap_a1", addr_log[1], DEPTH - 1);
    chk("wrap_a2", addr_log[2], 0);
    chk("wrap_a3", addr_log[3], 1);

    // Random backpressure.
    max_cnt = 0;
    run_burst(int'($urandom_range(0, DEPTH - 1)), 8, 1, 0, 0);
    chk("fifo_max_le2", max_cnt <= 2, 1);

    // Zero-length burst.
    run_burst(55, 0, 0, 0, 0);
    chk("len0_busy_c1", busy_log[0], 1);
    chk("len0_done_c1", done_log[0], 1);
    chk("len0_busy_c2", busy_log[1], 0);
    nv = 0;
    foreach (val_log[i]) nv += int'(val_log[i]);
    chk("len0_no_valid", nv, 0);

    // Reset mid-burst after three accepted elements.
    run_burst(300, 6, 0, 0, 3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_addr", ram_addr_r, 0);
    chk("mid_rst_data", out_data, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    run_burst(777, 2, 0, 0, 0);

    // Start pulsed mid-burst must be ignored.
    run_burst(200, 8, 1, 3, 0);
    chk("spur_idle_after", busy_log[busy_log.size() - 1], 0);

    // Random bursts, including some near the wrap point.
    for (int t = 0; t < 12; t++) begin
      int b;
      b = (t % 3 == 0) ? int'($urandom_range(DEPTH - 10, DEPTH - 1)) : int'($urandom_range(0, DEPTH - 1));
      max_cnt = 0;
      run_burst(b, int'($urandom_range(1, 24)), 1, 0, 0);
      chk("rand_fifo_max_le2", max_cnt <= 2, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
